// File: rtl/calc_port_scheduler.sv
// Shares one adder/shifter engine between four two-cycle calc requester ports:
// captures operands, rejects invalid commands, grants round-robin and routes results back.
module calc_port_scheduler #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 63
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req1_cmd_in,
    input  logic [3:0]        req2_cmd_in,
    input  logic [3:0]        req3_cmd_in,
    input  logic [3:0]        req4_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [DATA_W-1:0] req4_data_in,
    output logic [1:0]        out_resp1,
    output logic [1:0]        out_resp2,
    output logic [1:0]        out_resp3,
    output logic [1:0]        out_resp4,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [DATA_W-1:0] out_data4,
    output logic [3:0]        port_busy,
    output logic              alu_start,
    output logic [3:0]        alu_cmd,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic              alu_done,
    input  logic [1:0]        alu_resp,
    input  logic [DATA_W-1:0] alu_data,
    output logic [7:0]        dbg_port_state,
    output logic              dbg_eng_busy
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND, P_ISSUED} port_state_t;
    typedef enum logic {E_IDLE, E_BUSY} eng_state_t;

    logic [3:0]        cmd_in  [4];
    logic [DATA_W-1:0] data_in [4];

    port_state_t       st_q [4];
    port_state_t       st_d [4];
    logic [3:0]        cmd_q [4];
    logic [DATA_W-1:0] op1_q [4];
    logic [DATA_W-1:0] op2_q [4];
    logic [1:0]        resp_q [4];
    logic [1:0]        resp_d [4];
    logic [DATA_W-1:0] rdata_q [4];
    logic [DATA_W-1:0] rdata_d [4];

    eng_state_t        eng_q, eng_d;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [1:0]        rr_ptr;
    logic [3:0]        eligible;
    logic              grant;
    logic [1:0]        grant_idx;
    logic [DATA_W-1:0] grant_op2;
    logic              done_acc;
    logic              timeout_hit;

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    function automatic logic cmd_valid(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    // Engine handshake: alu_start is a one-cycle issue pulse with cmd/ops valid in that
    // cycle; alu_done is a one-cycle completion pulse carrying alu_resp/alu_data, honoured
    // only while an operation is outstanding (stray or late pulses are dropped).
    always_comb begin
        done_acc    = (eng_q == E_BUSY) && alu_done;
        timeout_hit = (eng_q == E_BUSY) && !alu_done && (tmo_cnt == TMO_LAST);

        for (int i = 0; i < 4; i++) begin
            eligible[i] = (st_q[i] == P_PEND) ||
                          ((st_q[i] == P_OP2) && cmd_valid(cmd_q[i]));
        end

        // Completion and re-grant may share a cycle, so the engine stays back-to-back.
        grant     = 1'b0;
        grant_idx = rr_ptr;
        if ((eng_q == E_IDLE) || done_acc || timeout_hit) begin
            for (int k = 1; k <= 4; k++) begin
                if (!grant && eligible[2'(rr_ptr + 2'(k))]) begin
                    grant     = 1'b1;
                    grant_idx = 2'(rr_ptr + 2'(k));
                end
            end
        end

        // A port granted straight out of OP2 has its op2 on the input bus this cycle.
        grant_op2 = (st_q[grant_idx] == P_OP2) ? data_in[grant_idx] : op2_q[grant_idx];

        eng_d = eng_q;
        if (grant) begin
            eng_d = E_BUSY;
        end else if (done_acc || timeout_hit) begin
            eng_d = E_IDLE;
        end

        for (int i = 0; i < 4; i++) begin
            st_d[i]    = st_q[i];
            resp_d[i]  = 2'd0;
            rdata_d[i] = '0;
            case (st_q[i])
                P_IDLE: begin
                    if (cmd_in[i] != 4'd0) st_d[i] = P_OP2;
                end
                P_OP2: begin
                    if (!cmd_valid(cmd_q[i])) begin
                        st_d[i]   = P_IDLE;
                        resp_d[i] = 2'd2;
                    end else if (grant && (grant_idx == 2'(i))) begin
                        st_d[i] = P_ISSUED;
                    end else begin
                        st_d[i] = P_PEND;
                    end
                end
                P_PEND: begin
                    if (grant && (grant_idx == 2'(i))) st_d[i] = P_ISSUED;
                end
                P_ISSUED: begin
                    if (done_acc) begin
                        st_d[i]    = P_IDLE;
                        resp_d[i]  = alu_resp;
                        rdata_d[i] = alu_data;
                    end else if (timeout_hit) begin
                        st_d[i]   = P_IDLE;
                        resp_d[i] = 2'd3;
                    end
                end
                default: st_d[i] = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            eng_q     <= E_IDLE;
            tmo_cnt   <= '0;
            rr_ptr    <= 2'd3;
            alu_start <= 1'b0;
            alu_cmd   <= 4'd0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            for (int i = 0; i < 4; i++) begin
                st_q[i]    <= P_IDLE;
                cmd_q[i]   <= 4'd0;
                op1_q[i]   <= '0;
                op2_q[i]   <= '0;
                resp_q[i]  <= 2'd0;
                rdata_q[i] <= '0;
            end
        end else begin
            eng_q     <= eng_d;
            alu_start <= grant;
            if (grant) begin
                tmo_cnt <= '0;
                rr_ptr  <= grant_idx;
                alu_cmd <= cmd_q[grant_idx];
                alu_op1 <= op1_q[grant_idx];
                alu_op2 <= grant_op2;
            end else if (eng_q == E_BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                st_q[i]    <= st_d[i];
                resp_q[i]  <= resp_d[i];
                rdata_q[i] <= rdata_d[i];
                if ((st_q[i] == P_IDLE) && (cmd_in[i] != 4'd0)) begin
                    cmd_q[i] <= cmd_in[i];
                    op1_q[i] <= data_in[i];
                end
                if (st_q[i] == P_OP2) op2_q[i] <= data_in[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            port_busy[i] = (st_q[i] != P_IDLE);
        end
    end

    assign out_resp1      = resp_q[0];
    assign out_resp2      = resp_q[1];
    assign out_resp3      = resp_q[2];
    assign out_resp4      = resp_q[3];
    assign out_data1      = rdata_q[0];
    assign out_data2      = rdata_q[1];
    assign out_data3      = rdata_q[2];
    assign out_data4      = rdata_q[3];
    assign dbg_port_state = {st_q[3], st_q[2], st_q[1], st_q[0]};
    assign dbg_eng_busy   = (eng_q == E_BUSY);

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Directed bench for calc_port_scheduler: single-port vector table plus hand-written
// sequences for arbitration order, timeout, mid-operation reset and ignored re-commands.
module tb_calc_port_scheduler;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 63;

    logic              c_clk = 1'b0;
    logic              reset;
    logic [3:0]        req_cmd  [4];
    logic [DATA_W-1:0] req_data [4];
    logic [1:0]        out_resp1, out_resp2, out_resp3, out_resp4;
    logic [DATA_W-1:0] out_data1, out_data2, out_data3, out_data4;
    logic [3:0]        port_busy;
    logic              alu_start;
    logic [3:0]        alu_cmd;
    logic [DATA_W-1:0] alu_op1, alu_op2;
    logic              alu_done;
    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_data;
    logic [7:0]        dbg_port_state;
    logic              dbg_eng_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          port;
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        int          lat;
        logic [1:0]  a_resp;
        logic [31:0] a_data;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        bit          exp_issue;
    } vec_t;

    vec_t vecs [8];

    calc_port_scheduler #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .c_clk(c_clk), .reset(reset),
        .req1_cmd_in(req_cmd[0]), .req2_cmd_in(req_cmd[1]),
        .req3_cmd_in(req_cmd[2]), .req4_cmd_in(req_cmd[3]),
        .req1_data_in(req_data[0]), .req2_data_in(req_data[1]),
        .req3_data_in(req_data[2]), .req4_data_in(req_data[3]),
        .out_resp1(out_resp1), .out_resp2(out_resp2),
        .out_resp3(out_resp3), .out_resp4(out_resp4),
        .out_data1(out_data1), .out_data2(out_data2),
        .out_data3(out_data3), .out_data4(out_data4),
        .port_busy(port_busy), .alu_start(alu_start), .alu_cmd(alu_cmd),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_done(alu_done),
        .alu_resp(alu_resp), .alu_data(alu_data),
        .dbg_port_state(dbg_port_state), .dbg_eng_busy(dbg_eng_busy)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] resp_of(input int p);
        case (p)
            0:       return out_resp1;
            1:       return out_resp2;
            2:       return out_resp3;
            default: return out_resp4;
        endcase
    endfunction

    function automatic logic [31:0] data_of(input int p);
        case (p)
            0:       return out_data1;
            1:       return out_data2;
            2:       return out_data3;
            default: return out_data4;
        endcase
    endfunction

    function automatic logic [2:0] resp_count();
        return 3'((out_resp1 != 0)) + 3'((out_resp2 != 0)) + 3'((out_resp3 != 0)) + 3'((out_resp4 != 0));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are observed and inputs applied on the falling edge.
    task automatic tick();
        @(negedge c_clk);
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 4; p++) begin
            req_cmd[p]  = 4'd0;
            req_data[p] = '0;
        end
        alu_done = 1'b0;
        alu_resp = 2'd0;
        alu_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("reset_busy", port_busy, 4'd0);
        check("reset_start", alu_start, 1'b0);
        reset = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        req_cmd[v.port]  = v.cmd;
        req_data[v.port] = v.op1;
        tick();
        check($sformatf("%s busy_op2", tag), port_busy[v.port], 1'b1);
        check($sformatf("%s no_early_start", tag), alu_start, 1'b0);
        req_cmd[v.port]  = 4'd0;
        req_data[v.port] = v.op2;
        tick();
        req_data[v.port] = '0;
        if (!v.exp_issue) begin
            check($sformatf("%s inv_resp", tag), resp_of(v.port), v.exp_resp);
            check($sformatf("%s inv_data", tag), data_of(v.port), v.exp_data);
            check($sformatf("%s inv_no_start", tag), alu_start, 1'b0);
            check($sformatf("%s inv_idle", tag), port_busy[v.port], 1'b0);
        end else begin
            check($sformatf("%s start", tag), alu_start, 1'b1);
            check($sformatf("%s alu_cmd", tag), alu_cmd, v.cmd);
            check($sformatf("%s alu_op1", tag), alu_op1, v.op1);
            check($sformatf("%s alu_op2", tag), alu_op2, v.op2);
            for (int i = 0; i < v.lat; i++) tick();
            alu_done = 1'b1;
            alu_resp = v.a_resp;
            alu_data = v.a_data;
            tick();
            alu_done = 1'b0;
            alu_resp = 2'd0;
            alu_data = '0;
            check($sformatf("%s resp", tag), resp_of(v.port), v.exp_resp);
            check($sformatf("%s data", tag), data_of(v.port), v.exp_data);
            check($sformatf("%s idle_after", tag), port_busy[v.port], 1'b0);
        end
        tick();
        check($sformatf("%s resp_clear", tag), resp_of(v.port), 2'd0);
        check($sformatf("%s data_clear", tag), data_of(v.port), 32'd0);
    endtask

    // All four ports request at once; engine answers 2 cycles after each start.
    // With reissue, port 1 sends a new command the cycle its response appears.
    task automatic run_burst(input int round, input bit reissue, input int exp_port [5], input int exp_n);
        logic [DATA_W-1:0] exp_q [$];
        int got_port [$];
        int got_cyc  [$];
        int done_at  = -1;
        int rsp_at   = -1;
        int rsp_port = 0;
        int cur_port = 0;
        int p0_phase = 0;
        logic [31:0] cur_exp = '0;

        for (int p = 0; p < 4; p++) begin
            req_cmd[p]  = 4'd1;
            req_data[p] = 32'h100 * (p + 1) + 32'(round * 16);
        end
        tick();
        for (int p = 0; p < 4; p++) begin
            req_cmd[p]  = 4'd0;
            req_data[p] = 32'h1000 * (p + 1);
        end
        tick();
        for (int p = 0; p < 4; p++) req_data[p] = '0;

        for (int c = 2; c < 24; c++) begin
            if (c == rsp_at) begin
                check($sformatf("burst%0d resp p%0d", round, rsp_port), resp_of(rsp_port), 2'd1);
                check($sformatf("burst%0d data p%0d", round, rsp_port), data_of(rsp_port), exp_q.pop_front());
                check($sformatf("burst%0d one_resp", round), resp_count(), 3'd1);
            end
            alu_done = 1'b0;
            alu_resp = 2'd0;
            alu_data = '0;
            if (c == done_at) begin
                alu_done = 1'b1;
                alu_resp = 2'd1;
                alu_data = cur_exp;
                exp_q.push_back(cur_exp);
                rsp_at   = c + 1;
                rsp_port = cur_port;
            end
            if (alu_start) begin
                cur_port = int'(alu_op1[11:8]) - 1;
                got_port.push_back(cur_port);
                got_cyc.push_back(c);
                check($sformatf("burst%0d cmd", round), alu_cmd, 4'd1);
                check($sformatf("burst%0d op2_port", round), alu_op2[15:12], 4'(cur_port + 1));
                cur_exp = alu_op1 + alu_op2;
                done_at = c + 2;
            end
            case (p0_phase)
                1: begin req_cmd[0] = 4'd0; req_data[0] = 32'h1900; p0_phase = 2; end
                2: begin req_data[0] = '0; p0_phase = 3; end
                default: ;
            endcase
            if (reissue && (p0_phase == 0) && (out_resp1 == 2'd1)) begin
                req_cmd[0]  = 4'd1;
                req_data[0] = 32'h190;
                p0_phase    = 1;
            end
            tick();
        end
        alu_done = 1'b0;
        check($sformatf("burst%0d n_starts", round), got_port.size(), exp_n);
        for (int k = 0; k < exp_n; k++) begin
            if (k < got_port.size()) begin
                check($sformatf("burst%0d order[%0d]", round, k), got_port[k], exp_port[k]);
                check($sformatf("burst%0d start_cyc[%0d]", round, k), got_cyc[k], 2 + 3 * k);
            end
        end
        check($sformatf("burst%0d all_answered", round), exp_q.size(), 0);
        check($sformatf("burst%0d idle", round), port_busy, 4'd0);
    endtask

    initial begin : main
        int got_to;
        int next_start;
        int n_start;
        int ord_a [5];
        int ord_b [5];

        vecs[0] = '{0, 4'd1,  32'h1,        32'h1FF_FFFF, 3, 2'd1, 32'h200_0000, 2'd1, 32'h200_0000, 1'b1};
        vecs[1] = '{1, 4'd3,  32'h1,        32'h2,        0, 2'd0, 32'h0,        2'd2, 32'h0,        1'b0};
        vecs[2] = '{1, 4'd4,  32'h7,        32'h8,        0, 2'd0, 32'h0,        2'd2, 32'h0,        1'b0};
        vecs[3] = '{1, 4'd5,  32'h8000_0001, 32'h1,       1, 2'd2, 32'h2,        2'd2, 32'h2,        1'b1};
        vecs[4] = '{2, 4'd2,  32'h5,        32'h7,        0, 2'd2, 32'hFFFF_FFFE, 2'd2, 32'hFFFF_FFFE, 1'b1};
        vecs[5] = '{3, 4'd6,  32'h100,      32'h4,        5, 2'd1, 32'h10,       2'd1, 32'h10,       1'b1};
        vecs[6] = '{3, 4'd15, 32'hAAAA,     32'h5555,     0, 2'd0, 32'h0,        2'd2, 32'h0,        1'b0};
        vecs[7] = '{0, 4'd7,  32'h1234,     32'h5678,     0, 2'd0, 32'h0,        2'd2, 32'h0,        1'b0};
        ord_a = '{0, 1, 2, 3, 0};
        ord_b = '{1, 2, 3, 0, 0};

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("rst out_resp", {out_resp4, out_resp3, out_resp2, out_resp1}, 8'd0);
        check("rst out_data", out_data1 | out_data2 | out_data3 | out_data4, 32'd0);
        check("rst port_busy", port_busy, 4'd0);
        check("rst alu_start", alu_start, 1'b0);
        check("rst alu_cmd", alu_cmd, 4'd0);
        check("rst alu_ops", alu_op1 | alu_op2, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Round-robin: fresh pointer favours port 1, then continues after last winner.
        do_reset();
        run_burst(1, 1'b1, ord_a, 5);
        run_burst(2, 1'b0, ord_b, 4);

        // Timeout on port 2 while port 3 waits; stray done afterwards.
        do_reset();
        req_cmd[1] = 4'd1; req_data[1] = 32'h201;
        req_cmd[2] = 4'd2; req_data[2] = 32'h301;
        tick();
        req_cmd[1] = 4'd0; req_data[1] = 32'h202;
        req_cmd[2] = 4'd0; req_data[2] = 32'h302;
        tick();
        req_data[1] = '0;
        req_data[2] = '0;
        check("to first_start", alu_start, 1'b1);
        check("to first_op1", alu_op1, 32'h201);
        got_to = -1;
        next_start = -1;
        for (int k = 1; k <= TIMEOUT + 4; k++) begin
            tick();
            if ((got_to > 0) && (k == got_to + 1)) check("to resp_clear", out_resp2, 2'd0);
            if ((out_resp2 != 2'd0) && (got_to < 0)) begin
                got_to = k;
                check("to resp", out_resp2, 2'd3);
                check("to data", out_data2, 32'd0);
            end
            if (alu_start && (next_start < 0)) begin
                next_start = k;
                check("to next_cmd", alu_cmd, 4'd2);
                check("to next_op1", alu_op1, 32'h301);
                check("to next_op2", alu_op2, 32'h302);
            end
        end
        check("to latency", got_to, TIMEOUT);
        check("to next_issue", (next_start >= TIMEOUT) && (next_start <= TIMEOUT + 1), 1'b1);
        alu_done = 1'b1; alu_resp = 2'd1; alu_data = 32'h603;
        tick();
        alu_done = 1'b0; alu_resp = 2'd0; alu_data = '0;
        check("to port3 resp", out_resp3, 2'd1);
        check("to port3 data", out_data3, 32'h603);
        tick();
        alu_done = 1'b1; alu_resp = 2'd1; alu_data = 32'hBAD;
        tick();
        alu_done = 1'b0; alu_resp = 2'd0; alu_data = '0;
        check("stray no_resp", resp_count(), 3'd0);
        tick();
        check("stray no_resp2", resp_count(), 3'd0);
        check("stray idle", port_busy, 4'd0);

        // Reset while port 3 issued and port 1 pending.
        do_reset();
        req_cmd[2] = 4'd1; req_data[2] = 32'h311;
        tick();
        req_cmd[2] = 4'd0; req_data[2] = 32'h312;
        req_cmd[0] = 4'd1; req_data[0] = 32'h111;
        tick();
        check("mrst start", alu_start, 1'b1);
        check("mrst op1", alu_op1, 32'h311);
        req_cmd[0] = 4'd0; req_data[0] = 32'h112; req_data[2] = '0;
        tick();
        req_data[0] = '0;
        check("mrst busy_before", port_busy, 4'b0101);
        reset = 1'b1;
        tick();
        check("mrst busy_after", port_busy, 4'd0);
        check("mrst no_resp", resp_count(), 3'd0);
        reset = 1'b0;
        tick();
        alu_done = 1'b1; alu_resp = 2'd1; alu_data = 32'h999;
        tick();
        alu_done = 1'b0; alu_resp = 2'd0; alu_data = '0;
        check("mrst late_done", resp_count(), 3'd0);
        check("mrst no_start", alu_start, 1'b0);
        tick();
        check("mrst late_done2", resp_count(), 3'd0);
        run_vec(vecs[0], "mrst_new");

        // Second command while pending is ignored; original operands are issued.
        do_reset();
        req_cmd[1] = 4'd1; req_data[1] = 32'h221;
        tick();
        req_cmd[1] = 4'd0; req_data[1] = 32'h222;
        req_cmd[0] = 4'd1; req_data[0] = 32'hA1;
        tick();
        req_data[1] = '0;
        req_cmd[0] = 4'd0; req_data[0] = 32'hB1;
        check("ign start1", alu_start, 1'b1);
        check("ign op1_p2", alu_op1, 32'h221);
        tick();
        req_cmd[0] = 4'd2; req_data[0] = 32'hDEAD;
        check("ign busy", port_busy, 4'b0011);
        tick();
        req_cmd[0] = 4'd0; req_data[0] = 32'hBEEF;
        tick();
        req_data[0] = '0;
        tick();
        alu_done = 1'b1; alu_resp = 2'd1; alu_data = 32'h443;
        tick();
        alu_done = 1'b0;
        check("ign p2 resp", out_resp2, 2'd1);
        check("ign p2 data", out_data2, 32'h443);
        check("ign start2", alu_start, 1'b1);
        check("ign cmd", alu_cmd, 4'd1);
        check("ign op1", alu_op1, 32'hA1);
        check("ign op2", alu_op2, 32'hB1);
        tick();
        alu_done = 1'b1; alu_resp = 2'd1; alu_data = 32'h152;
        tick();
        alu_done = 1'b0; alu_resp = 2'd0; alu_data = '0;
        check("ign p1 resp", out_resp1, 2'd1);
        check("ign p1 data", out_data1, 32'h152);
        tick();
        check("ign p1 resp_clear", out_resp1, 2'd0);
        check("ign idle", port_busy, 4'd0);
        n_start = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (alu_start) n_start++;
        end
        check("ign no_extra_start", n_start, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
